// File: rtl/pc_sequencer_pkg.sv
// Shared command, state and fault-code definitions for the program-counter sequencer.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT    = 3'd0,
    SEQ_JUMP    = 3'd1,
    SEQ_CALL    = 3'd2,
    SEQ_RET     = 3'd3,
    SEQ_JZ      = 3'd4,
    SEQ_JNZ     = 3'd5,
    SEQ_SETLOOP = 3'd6,
    SEQ_DJNZ    = 3'd7
  } seq_cmd_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } seq_state_e;

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses; only the pointer is reset, entries are don't-care until written.
module return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             isResetN,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_ptr;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;

  assign w_wr_idx  = AW'(r_ptr);
  assign w_top_idx = AW'(r_ptr - DW'(1));
  assign depth     = r_ptr;
  assign full      = (r_ptr == DW'(DEPTH));
  assign empty     = (r_ptr == '0);
  assign top       = empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      r_ptr <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (push && !full) begin
      r_ptr <= r_ptr + DW'(1);
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - DW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!clear && push && !full) begin
      r_mem[w_wr_idx] <= pushData;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, hardware loop counter and RUN/FAULT control around a return stack.
// state    | meaning
// ST_RUN   | one command per enabled cycle
// ST_FAULT | stack over/underflow seen; everything frozen until clearFault
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int STACK_DEPTH  = 16,
  parameter int LOOP_WIDTH   = 8,
  localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   isResetN,
  input  logic                   enable,
  input  logic [2:0]             cmd,
  input  logic [PC_WIDTH-1:0]    target,
  input  logic                   isZero,
  input  logic                   clearFault,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [DEPTH_WIDTH-1:0] stackDepth,
  output logic [PC_WIDTH-1:0]    returnTop,
  output logic [LOOP_WIDTH-1:0]  loopCount,
  output logic                   fault,
  output logic [1:0]             faultCode
);

  seq_state_e            r_state, w_state_next;
  logic [PC_WIDTH-1:0]   r_pc, w_pc_next, w_pc_inc;
  logic [LOOP_WIDTH-1:0] r_loop, w_loop_next, w_loop_dec;
  logic [1:0]            r_fault_code, w_fault_code_next;
  logic                  w_push, w_pop, w_clear, w_full, w_empty;

  assign w_pc_inc   = r_pc + PC_WIDTH'(1);
  assign w_loop_dec = r_loop - LOOP_WIDTH'(1);

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock    (clock),
    .isResetN (isResetN),
    .clear    (w_clear),
    .push     (w_push),
    .pop      (w_pop),
    .pushData (w_pc_inc),
    .top      (returnTop),
    .depth    (stackDepth),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      r_state      <= ST_RUN;
      r_pc         <= '0;
      r_loop       <= '0;
      r_fault_code <= FAULT_NONE;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_loop       <= w_loop_next;
      r_fault_code <= w_fault_code_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_loop_next       = r_loop;
    w_fault_code_next = r_fault_code;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_clear           = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (enable) begin
          case (seq_cmd_e'(cmd))
            SEQ_NEXT: w_pc_next = w_pc_inc;
            SEQ_JUMP: w_pc_next = target;
            SEQ_CALL: begin
              if (!w_full) begin
                w_push    = 1'b1;
                w_pc_next = target;
              end else begin
                w_state_next      = ST_FAULT;
                w_fault_code_next = FAULT_OVERFLOW;
              end
            end
            SEQ_RET: begin
              if (!w_empty) begin
                w_pop     = 1'b1;
                w_pc_next = returnTop;
              end else begin
                w_state_next      = ST_FAULT;
                w_fault_code_next = FAULT_UNDERFLOW;
              end
            end
            SEQ_JZ:  w_pc_next = isZero ? target : w_pc_inc;
            SEQ_JNZ: w_pc_next = isZero ? w_pc_inc : target;
            SEQ_SETLOOP: begin
              w_loop_next = target[LOOP_WIDTH-1:0];
              w_pc_next   = w_pc_inc;
            end
            SEQ_DJNZ: begin
              // an exhausted counter falls through rather than wrapping to all-ones
              if (r_loop == '0) begin
                w_pc_next = w_pc_inc;
              end else begin
                w_loop_next = w_loop_dec;
                w_pc_next   = (w_loop_dec != '0) ? target : w_pc_inc;
              end
            end
            default: w_pc_next = r_pc;
          endcase
        end
      end
      ST_FAULT: begin
        if (clearFault) begin
          w_state_next      = ST_RUN;
          w_pc_next         = '0;
          w_loop_next       = '0;
          w_fault_code_next = FAULT_NONE;
          w_clear           = 1'b1;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign pc        = r_pc;
  assign loopCount = r_loop;
  assign fault     = (r_state == ST_FAULT);
  assign faultCode = r_fault_code;

endmodule
